// File: rtl/if_fetch_stage_if.sv
// ---------------------------------------------------------------------------
// if_fetch_stage_if
// Bus bundle between the instruction-fetch stage and its surroundings.
//   imem_addr      word address to the combinational instruction memory
//   imem_rdata     instruction word for imem_addr, same cycle
//   redirect_valid execute stage requests a PC change
//   redirect_pc    redirect target byte address (bits [1:0] ignored)
//   out_valid      decode-side head entry valid
//   out_ready      decode accepts the head entry this cycle
//   out_instr      head instruction
//   out_pc         head instruction byte PC
//   out_pc_plus4   out_pc + 4
//   fetch_count    fetch buffer occupancy
// Modports: master = fetch stage side, slave = memory/execute/decode side.
// ---------------------------------------------------------------------------
interface if_fetch_stage_if #(
  parameter int unsigned IMEM_AW = 5
);
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_instr;
  logic [31:0]        out_pc;
  logic [31:0]        out_pc_plus4;
  logic [2:0]         fetch_count;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output out_pc_plus4,
    output fetch_count
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  out_pc_plus4,
    input  fetch_count
  );
endinterface

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch front end: owns the PC, reads the combinational
// instruction memory, buffers {instr, pc} in a DEPTH-entry FIFO and presents
// the head to decode with a valid/ready handshake. A redirect flushes the
// buffer and reloads the PC.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    if_fetch_stage_if.master (imem, redirect and decode signals)
// Optional feature: define IF_EARLY_JUMP_EN to follow J-format words
// (opcode 6'b000010) directly at fetch instead of stepping to pc+4.
// ---------------------------------------------------------------------------
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMEM_AW  = 5,
  parameter int unsigned DEPTH    = 2
) (
  input logic              clk,
  input logic              reset,
  if_fetch_stage_if.master bus
);

  localparam int unsigned IdxW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0]  DepthC  = 3'(DEPTH);
  // Pointers run over 0..2*DEPTH-1 so full and empty are distinguishable.
  localparam logic [2:0]  PtrLast = 3'(2 * DEPTH - 1);
  localparam logic [2:0]  PtrSpan = 3'((2 * DEPTH) % 8);

  logic [31:0] r_pc;
  logic [31:0] r_instr_mem [DEPTH];
  logic [31:0] r_pc_mem    [DEPTH];
  logic [2:0]  r_wr_ptr;
  logic [2:0]  r_rd_ptr;
  logic [2:0]  r_count;

  logic [31:0] w_pc_d;
  logic [2:0]  w_wr_ptr_d;
  logic [2:0]  w_rd_ptr_d;
  logic [2:0]  w_count_d;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_seq;
  logic        w_out_valid;
  logic        w_pop;
  logic        w_fetch_en;
  logic [31:0] w_head_pc;
  logic        w_unused;

  function automatic logic [2:0] ptr_inc(input logic [2:0] p);
    return (p == PtrLast) ? 3'd0 : p + 3'd1;
  endfunction

  function automatic logic [IdxW-1:0] ptr_idx(input logic [2:0] p);
    if (p >= DepthC) begin
      return IdxW'(p - DepthC);
    end
    return IdxW'(p);
  endfunction

  // Occupancy from pointer difference, modulo the pointer span.
  function automatic logic [2:0] ptr_diff(input logic [2:0] wr, input logic [2:0] rd);
    logic [2:0] d;
    d = wr - rd;
    if (wr < rd) begin
      d = d + PtrSpan;
    end
    return d;
  endfunction

  assign w_unused    = ^bus.redirect_pc[1:0];
  assign w_out_valid = (r_count != 3'd0);
  assign w_pop       = w_out_valid & bus.out_ready;
  // A full buffer can still fetch when the head leaves in the same cycle.
  assign w_fetch_en  = ~bus.redirect_valid & ((r_count < DepthC) | w_pop);
  assign w_pc_plus4  = r_pc + 32'd4;

`ifdef IF_EARLY_JUMP_EN
  logic w_is_jump;
  assign w_is_jump = (bus.imem_rdata[31:26] == 6'b000010);
  assign w_pc_seq  = w_is_jump ? {w_pc_plus4[31:28], bus.imem_rdata[25:0], 2'b00}
                               : w_pc_plus4;
`else
  assign w_pc_seq  = w_pc_plus4;
`endif

  always_comb begin
    w_pc_d     = r_pc;
    w_wr_ptr_d = r_wr_ptr;
    w_rd_ptr_d = r_rd_ptr;
    if (bus.redirect_valid) begin
      w_pc_d     = {bus.redirect_pc[31:2], 2'b00};
      w_wr_ptr_d = 3'd0;
      w_rd_ptr_d = 3'd0;
    end else begin
      if (w_fetch_en) begin
        w_pc_d     = w_pc_seq;
        w_wr_ptr_d = ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        w_rd_ptr_d = ptr_inc(r_rd_ptr);
      end
    end
    w_count_d = ptr_diff(w_wr_ptr_d, w_rd_ptr_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc     <= RESET_PC;
      r_wr_ptr <= 3'd0;
      r_rd_ptr <= 3'd0;
      r_count  <= 3'd0;
    end else begin
      r_pc     <= w_pc_d;
      r_wr_ptr <= w_wr_ptr_d;
      r_rd_ptr <= w_rd_ptr_d;
      r_count  <= w_count_d;
    end
  end

  // When full and popping, the tail slot equals the head slot being freed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_instr_mem[i] <= 32'd0;
        r_pc_mem[i]    <= 32'd0;
      end
    end else if (w_fetch_en) begin
      r_instr_mem[ptr_idx(r_wr_ptr)] <= bus.imem_rdata;
      r_pc_mem[ptr_idx(r_wr_ptr)]    <= r_pc;
    end
  end

  assign w_head_pc        = w_out_valid ? r_pc_mem[ptr_idx(r_rd_ptr)] : 32'd0;
  assign bus.imem_addr    = r_pc[IMEM_AW+1:2];
  assign bus.out_valid    = w_out_valid;
  assign bus.out_instr    = w_out_valid ? r_instr_mem[ptr_idx(r_rd_ptr)] : 32'd0;
  assign bus.out_pc       = w_head_pc;
  assign bus.out_pc_plus4 = w_out_valid ? (w_head_pc + 32'd4) : 32'd0;
  assign bus.fetch_count  = r_count;

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
// Directed bench for if_fetch_stage. A queue-based model of the fetch buffer
// is advanced on every clock edge; one process compares the DUT against it
// on every falling edge, and the stimulus adds hand-computed literals.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam int unsigned ImemAw  = 5;
  localparam int unsigned Depth   = 2;
`ifdef IF_EARLY_JUMP_EN
  localparam logic [31:0] JumpNextPc = 32'd20;
`else
  localparam logic [31:0] JumpNextPc = 32'd12;
`endif

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [31:0] imem [32];

  entry_t      q[$];
  logic [31:0] mpc;
  int          checks = 0;
  int          errors = 0;

  if_fetch_stage_if #(.IMEM_AW(ImemAw)) bus ();

  if_fetch_stage #(
    .RESET_PC(ResetPc),
    .IMEM_AW (ImemAw),
    .DEPTH   (Depth)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_rdata = imem[bus.imem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of the fetch rules, written against the queue.
  task automatic model_step();
    bit          pop;
    entry_t      e;
    logic [31:0] nxt;
    pop = (q.size() != 0) && bus.out_ready;
    if (bus.redirect_valid) begin
      q.delete();
      mpc = {bus.redirect_pc[31:2], 2'b00};
    end else if ((q.size() < int'(Depth)) || pop) begin
      if (pop) begin
        void'(q.pop_front());
      end
      e.instr = imem[mpc[6:2]];
      e.pc    = mpc;
      q.push_back(e);
      nxt = mpc + 32'd4;
`ifdef IF_EARLY_JUMP_EN
      if (e.instr[31:26] == 6'b000010) begin
        nxt = {nxt[31:28], e.instr[25:0], 2'b00};
      end
`endif
      mpc = nxt;
    end
  endtask

  initial begin
    mpc = ResetPc;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        q.delete();
        mpc = ResetPc;
      end else begin
        model_step();
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_count", 32'(bus.fetch_count), 32'd0);
        check("rst_instr", bus.out_instr, 32'd0);
        check("rst_pc", bus.out_pc, 32'd0);
        check("rst_pc4", bus.out_pc_plus4, 32'd0);
      end else begin
        check("valid", 32'(bus.out_valid), 32'(q.size() != 0));
        check("count", 32'(bus.fetch_count), 32'(q.size()));
        if (q.size() != 0) begin
          check("instr", bus.out_instr, q[0].instr);
          check("pc", bus.out_pc, q[0].pc);
          check("pc4", bus.out_pc_plus4, q[0].pc + 32'd4);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      imem[i] = 32'h1000_0000 + 32'(i);
    end
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;

    // Reset, then steady stream with out_ready high.
    repeat (2) @(negedge clk);
    check("lit_rst_valid", 32'(bus.out_valid), 32'd0);
    #1 reset = 1'b1;
    @(negedge clk);
    check("lit_s0_pc", bus.out_pc, 32'h0);
    check("lit_s0_instr", bus.out_instr, 32'h1000_0000);
    check("lit_s0_count", 32'(bus.fetch_count), 32'd1);
    @(negedge clk);
    check("lit_s1_pc", bus.out_pc, 32'h4);
    check("lit_s1_instr", bus.out_instr, 32'h1000_0001);
    @(negedge clk);
    check("lit_s2_pc", bus.out_pc, 32'h8);
    check("lit_s2_pc4", bus.out_pc_plus4, 32'hC);
    check("lit_s2_count", 32'(bus.fetch_count), 32'd1);
    repeat (3) @(negedge clk);

    // Asynchronous reset between edges mid-stream.
    #1 reset = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("lit_async_valid", 32'(bus.out_valid), 32'd0);
    check("lit_async_count", 32'(bus.fetch_count), 32'd0);
    @(negedge clk);
    #1 reset = 1'b1;

    // Stall: buffer fills to Depth and the PC holds.
    @(negedge clk);
    check("lit_restart_pc", bus.out_pc, ResetPc);
    check("lit_stall_c1", 32'(bus.fetch_count), 32'd1);
    @(negedge clk);
    check("lit_stall_c2", 32'(bus.fetch_count), 32'd2);
    check("lit_stall_addr", 32'(bus.imem_addr), 32'd2);
    repeat (3) @(negedge clk);
    check("lit_hold_count", 32'(bus.fetch_count), 32'd2);
    check("lit_hold_instr", bus.out_instr, 32'h1000_0000);
    check("lit_hold_addr", 32'(bus.imem_addr), 32'd2);

    // Release: full buffer pushes and pops in the same cycle.
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    check("lit_rel_pc1", bus.out_pc, 32'h4);
    check("lit_rel_count1", 32'(bus.fetch_count), 32'd2);
    @(negedge clk);
    check("lit_rel_pc2", bus.out_pc, 32'h8);
    check("lit_rel_instr2", bus.out_instr, 32'h1000_0002);
    check("lit_rel_count2", 32'(bus.fetch_count), 32'd2);

    // Redirect with two words buffered and a simultaneous pop.
    #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0043;
    @(negedge clk);
    check("lit_redir_valid", 32'(bus.out_valid), 32'd0);
    check("lit_redir_count", 32'(bus.fetch_count), 32'd0);
    check("lit_redir_addr", 32'(bus.imem_addr), 32'h10);
    #1 bus.redirect_valid = 1'b0;
    @(negedge clk);
    check("lit_tgt_pc", bus.out_pc, 32'h40);
    check("lit_tgt_instr", bus.out_instr, 32'h1000_0010);
    @(negedge clk);
    check("lit_tgt_pc_next", bus.out_pc, 32'h44);

    // Redirect to the top of the address space: pc+4 wraps to 0.
    #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFE;
    @(negedge clk);
    #1 bus.redirect_valid = 1'b0;
    @(negedge clk);
    check("lit_wrap_pc", bus.out_pc, 32'hFFFF_FFFC);
    check("lit_wrap_pc4", bus.out_pc_plus4, 32'h0);
    check("lit_wrap_instr", bus.out_instr, 32'h1000_001F);
    @(negedge clk);
    check("lit_wrap_next", bus.out_pc, 32'h0);

    // J word at pc 8.
    #1 reset = 1'b0;
    imem[2] = 32'h0800_0005;
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("lit_j_pc0", bus.out_pc, 32'h0);
    @(negedge clk);
    check("lit_j_pc1", bus.out_pc, 32'h4);
    @(negedge clk);
    check("lit_j_pc2", bus.out_pc, 32'h8);
    check("lit_j_instr", bus.out_instr, 32'h0800_0005);
    @(negedge clk);
    check("lit_j_pc3", bus.out_pc, JumpNextPc);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
